// File: rtl/eoc_monitor_if.sv
// Bundle of control, scratch-write stream and status signals for eoc_monitor.
// The master side arms and feeds the monitor; the slave side is the monitor itself.
interface eoc_monitor_if #(
  parameter int NumChan      = 4,
  parameter int CodeWidth    = 32,
  parameter int TimeoutWidth = 32
) ();
  localparam int IdxWidth = (NumChan > 1) ? $clog2(NumChan) : 1;

  logic                                start_i;
  logic                                clear_i;
  logic                                mode_i;
  logic [NumChan-1:0]                  chan_en_i;
  logic [TimeoutWidth-1:0]             timeout_i;
  logic [NumChan-1:0]                  wr_valid_i;
  logic [NumChan-1:0][CodeWidth-1:0]   wr_data_i;

  logic                                busy_o;
  logic                                done_o;
  logic                                timeout_o;
  logic                                pass_o;
  logic [CodeWidth-2:0]                exit_code_o;
  logic [IdxWidth-1:0]                 fail_idx_o;
  logic [NumChan-1:0]                  chan_done_o;

  modport master (
    output start_i, clear_i, mode_i, chan_en_i, timeout_i, wr_valid_i, wr_data_i,
    input  busy_o, done_o, timeout_o, pass_o, exit_code_o, fail_idx_o, chan_done_o
  );

  modport slave (
    input  start_i, clear_i, mode_i, chan_en_i, timeout_i, wr_valid_i, wr_data_i,
    output busy_o, done_o, timeout_o, pass_o, exit_code_o, fail_idx_o, chan_done_o
  );
endinterface

// File: rtl/eoc_monitor.sv
// Multi-channel end-of-computation monitor: latches the first EOC exit code per
// channel and reports one aggregated completion, pass/fail and timeout status.
module eoc_monitor #(
  parameter int NumChan      = 4,
  parameter int CodeWidth    = 32,
  parameter int TimeoutWidth = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  eoc_monitor_if.slave bus
);
  localparam int IdxWidth = (NumChan > 1) ? $clog2(NumChan) : 1;

  typedef enum logic [1:0] {StIdle, StArmed, StDone, StTimeout} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [NumChan-1:0]      r_chanDone;
  logic [NumChan-1:0]      r_chanEn;
  logic [CodeWidth-2:0]    r_code [NumChan];
  logic [TimeoutWidth-1:0] r_timeout;
  logic [TimeoutWidth-1:0] r_count;

  logic                    w_armed;
  logic                    w_arm;
  logic [NumChan-1:0]      w_capture;
  logic [NumChan-1:0]      w_nextDone;
  logic [NumChan-1:0]      w_doneEn;
  logic                    w_complete;
  logic                    w_expire;
  logic [CodeWidth-2:0]    w_exitCode;
  logic [IdxWidth-1:0]     w_failIdx;
  logic                    w_allZero;

  assign w_armed = (r_state == StArmed);
  assign w_arm   = bus.start_i && !w_armed;

  always_comb begin
    w_capture = '0;
    for (int i = 0; i < NumChan; i++) begin
      w_capture[i] = w_armed && r_chanEn[i] && !r_chanDone[i] &&
                     bus.wr_valid_i[i] && bus.wr_data_i[i][0];
    end
  end

  assign w_nextDone = r_chanDone | w_capture;
  assign w_doneEn   = w_nextDone & r_chanEn;

  // An empty enable mask completes immediately in either mode.
  always_comb begin
    w_complete = 1'b0;
    if (r_chanEn == '0) begin
      w_complete = 1'b1;
    end else if (bus.mode_i) begin
      w_complete = |w_doneEn;
    end else begin
      w_complete = (w_doneEn == r_chanEn);
    end
  end

  assign w_expire = (r_timeout != '0) && (r_count == (r_timeout - TimeoutWidth'(1)));

  always_comb begin
    w_nextState = r_state;
    if (bus.clear_i) begin
      w_nextState = StIdle;
    end else begin
      case (r_state)
        StArmed: begin
          if (w_complete) begin
            w_nextState = StDone;
          end else if (w_expire) begin
            w_nextState = StTimeout;
          end
        end
        default: begin
          if (bus.start_i) begin
            w_nextState = StArmed;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_chanDone <= '0;
      r_chanEn   <= '0;
      r_timeout  <= '0;
      r_count    <= '0;
      for (int i = 0; i < NumChan; i++) begin
        r_code[i] <= '0;
      end
    end else begin
      r_state <= w_nextState;
      if (bus.clear_i) begin
        r_chanDone <= '0;
        r_chanEn   <= '0;
        r_timeout  <= '0;
        r_count    <= '0;
        for (int i = 0; i < NumChan; i++) begin
          r_code[i] <= '0;
        end
      end else if (w_arm) begin
        r_chanDone <= '0;
        r_chanEn   <= bus.chan_en_i;
        r_timeout  <= bus.timeout_i;
        r_count    <= '0;
        for (int i = 0; i < NumChan; i++) begin
          r_code[i] <= '0;
        end
      end else if (w_armed) begin
        r_chanDone <= w_nextDone;
        for (int i = 0; i < NumChan; i++) begin
          if (w_capture[i]) begin
            r_code[i] <= bus.wr_data_i[i][CodeWidth-1:1];
          end
        end
        // Saturate so the no-timeout mode never wraps back to zero.
        if (r_count != '1) begin
          r_count <= r_count + TimeoutWidth'(1);
        end
      end
    end
  end

  // Descending scan so the lowest-index failing channel is reported.
  always_comb begin
    w_exitCode = '0;
    w_failIdx  = '0;
    w_allZero  = 1'b1;
    for (int i = NumChan - 1; i >= 0; i--) begin
      if (r_chanDone[i] && (r_code[i] != '0)) begin
        w_exitCode = r_code[i];
        w_failIdx  = IdxWidth'(i);
        w_allZero  = 1'b0;
      end
    end
  end

  assign bus.busy_o      = w_armed;
  assign bus.done_o      = (r_state == StDone);
  assign bus.timeout_o   = (r_state == StTimeout);
  assign bus.pass_o      = (r_state == StDone) && w_allZero;
  assign bus.exit_code_o = w_exitCode;
  assign bus.fail_idx_o  = w_failIdx;
  assign bus.chan_done_o = r_chanDone;
endmodule

// File: tb/tb_eoc_monitor.sv
// Scenario bench for eoc_monitor: each run pushes its expected end status to a
// scoreboard queue, drives a cycle-scheduled write stream, then pops and compares.
module tb_eoc_monitor;
  logic clk_i = 1'b0;
  logic rst_i;

  eoc_monitor_if #(.NumChan(4), .CodeWidth(32), .TimeoutWidth(32)) bus ();

  eoc_monitor #(.NumChan(4), .CodeWidth(32), .TimeoutWidth(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        tmo;
    logic        pass;
    logic [30:0] code;
    logic [1:0]  idx;
    logic [3:0]  chanDone;
  } res_t;

  typedef struct {
    res_t res;
    int   lat;
  } exp_t;

  typedef struct {
    int          cyc;
    int          ch;
    logic [31:0] data;
  } wr_t;

  exp_t sb[$];
  wr_t  sched[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic res_t obs();
    return {bus.busy_o, bus.done_o, bus.timeout_o, bus.pass_o,
            bus.exit_code_o, bus.fail_idx_o, bus.chan_done_o};
  endfunction

  function automatic res_t mk(input logic busy, input logic done, input logic tmo,
                              input logic pass, input logic [30:0] code,
                              input logic [1:0] idx, input logic [3:0] cd);
    return {busy, done, tmo, pass, code, idx, cd};
  endfunction

  task automatic pushExp(input res_t r, input int lat);
    exp_t e;
    e.res = r;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // A negative channel number schedules a start_i pulse instead of a write.
  task automatic addW(input int cyc, input int ch, input logic [31:0] data);
    wr_t w;
    w.cyc  = cyc;
    w.ch   = ch;
    w.data = data;
    sched.push_back(w);
  endtask

  task automatic arm(input logic mode, input logic [3:0] en, input logic [31:0] tmo);
    bus.clear_i   = 1'b0;
    bus.mode_i    = mode;
    bus.chan_en_i = en;
    bus.timeout_i = tmo;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
  endtask

  task automatic runArmed(input int maxCycles, output int latency, output bit ended);
    latency = 0;
    ended   = 1'b0;
    for (int k = 1; k <= maxCycles && !ended; k++) begin
      bus.wr_valid_i = '0;
      bus.start_i    = 1'b0;
      foreach (sched[j]) begin
        if (sched[j].cyc == k) begin
          if (sched[j].ch < 0) begin
            bus.start_i = 1'b1;
          end else begin
            bus.wr_valid_i[sched[j].ch] = 1'b1;
            bus.wr_data_i[sched[j].ch]  = sched[j].data;
          end
        end
      end
      tick();
      if (bus.done_o || bus.timeout_o) begin
        ended   = 1'b1;
        latency = k;
      end
    end
    bus.wr_valid_i = '0;
    bus.start_i    = 1'b0;
    sched.delete();
  endtask

  task automatic test_reset();
    res_t r;
    rst_i          = 1'b1;
    bus.start_i    = 1'b1;
    bus.wr_valid_i = '1;
    tick();
    tick();
    rst_i          = 1'b0;
    bus.start_i    = 1'b0;
    bus.wr_valid_i = '0;
    r = obs();
    checks++;
    if (r !== mk(0, 0, 0, 0, 0, 0, 4'h0)) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", r, mk(0, 0, 0, 0, 0, 0, 4'h0));
    end
  endtask

  task automatic test_all_pass();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b0, 4'hF, 32'd0);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL arm_busy: got %b expected 1", bus.busy_o);
    end
    pushExp(mk(0, 1, 0, 1, 0, 0, 4'hF), 20);
    addW(5, 0, 32'h1); addW(9, 1, 32'h1); addW(9, 2, 32'h1); addW(20, 3, 32'h1);
    runArmed(40, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL all_pass_status: got %h expected %h", r, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL all_pass_latency: got %0d expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_all_fail();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b0, 4'hF, 32'd0);
    pushExp(mk(0, 1, 0, 0, 31'd5, 2'd1, 4'hF), 8);
    addW(2, 0, 32'h1); addW(4, 2, 32'h7); addW(6, 1, 32'hB); addW(8, 3, 32'h1);
    runArmed(30, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL all_fail_status: got %h expected %h", r, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL all_fail_latency: got %0d expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_any_enable();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b1, 4'b0100, 32'd0);
    pushExp(mk(0, 1, 0, 1, 0, 0, 4'b0100), 7);
    addW(3, 0, 32'h1); addW(7, 2, 32'h1);
    runArmed(30, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL any_status: got %h expected %h", r, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL any_latency: got %0d expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_empty_mask();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b0, 4'b0000, 32'd0);
    pushExp(mk(0, 1, 0, 1, 0, 0, 4'h0), 1);
    addW(1, 1, 32'h1);
    runArmed(10, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL empty_status: got %h expected %h", r, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL empty_latency: got %0d expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_timeout();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b0, 4'hF, 32'd100);
    pushExp(mk(0, 0, 1, 0, 0, 0, 4'b0001), 100);
    addW(10, 0, 32'h1);
    runArmed(150, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL timeout_status: got %h expected %h", r, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got %0d expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_expiry_race();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b0, 4'hF, 32'd100);
    pushExp(mk(0, 1, 0, 1, 0, 0, 4'hF), 100);
    addW(5, 0, 32'h1); addW(5, 1, 32'h1); addW(5, 2, 32'h1); addW(100, 3, 32'h1);
    runArmed(150, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL race_status: got %h expected %h", r, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL race_latency: got %0d expected %0d", lat, e.lat);
    end
  endtask

  // Also confirms that writes arriving after DONE leave the results untouched.
  task automatic test_first_eoc();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b0, 4'b1001, 32'd0);
    pushExp(mk(0, 1, 0, 0, 31'd2, 2'd3, 4'b1001), 8);
    addW(2, 3, 32'h2); addW(4, 3, 32'h5); addW(6, 3, 32'h3); addW(8, 0, 32'h1);
    runArmed(30, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL first_eoc_status: got %h expected %h", r, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL first_eoc_latency: got %0d expected %0d", lat, e.lat);
    end
    bus.wr_valid_i   = 4'b0110;
    bus.wr_data_i[1] = 32'h7;
    bus.wr_data_i[2] = 32'h9;
    tick();
    bus.wr_valid_i = '0;
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL outside_armed: got %h expected %h", r, e.res);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b0, 4'hF, 32'd20);
    r = obs();
    checks++;
    if (r !== mk(1, 0, 0, 0, 0, 0, 4'h0)) begin
      errors++;
      $display("[TB] FAIL rearm_cleared: got %h expected %h", r, mk(1, 0, 0, 0, 0, 0, 4'h0));
    end
    pushExp(mk(0, 0, 1, 0, 0, 0, 4'b0001), 20);
    addW(3, 0, 32'h1); addW(10, -1, 32'h0);
    runArmed(60, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL armed_start_status: got %h expected %h", r, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL armed_start_latency: got %0d expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_mid_reset();
    res_t r; int lat; bit ended;
    arm(1'b0, 4'hF, 32'd0);
    addW(3, 0, 32'h1);
    runArmed(5, lat, ended);
    r = obs();
    checks++;
    if (r !== mk(1, 0, 0, 0, 0, 0, 4'b0001)) begin
      errors++;
      $display("[TB] FAIL pre_reset: got %h expected %h", r, mk(1, 0, 0, 0, 0, 0, 4'b0001));
    end
    rst_i          = 1'b1;
    bus.start_i    = 1'b1;
    bus.wr_valid_i = '1;
    for (int i = 0; i < 4; i++) bus.wr_data_i[i] = 32'h3;
    tick();
    rst_i          = 1'b0;
    bus.start_i    = 1'b0;
    bus.wr_valid_i = '0;
    r = obs();
    checks++;
    if (r !== mk(0, 0, 0, 0, 0, 0, 4'h0)) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %h expected %h", r, mk(0, 0, 0, 0, 0, 0, 4'h0));
    end
  endtask

  task automatic test_clear_start();
    exp_t e; res_t r; int lat; bit ended;
    arm(1'b1, 4'b0010, 32'd0);
    pushExp(mk(0, 1, 0, 0, 31'd5, 2'd1, 4'b0010), 2);
    addW(2, 1, 32'hB);
    runArmed(20, lat, ended);
    e = sb.pop_front();
    r = obs();
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("[TB] FAIL pre_clear_status: got %h expected %h", r, e.res);
    end
    bus.clear_i = 1'b1;
    bus.start_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    bus.start_i = 1'b0;
    r = obs();
    checks++;
    if (r !== mk(0, 0, 0, 0, 0, 0, 4'h0)) begin
      errors++;
      $display("[TB] FAIL clear_beats_start: got %h expected %h", r, mk(0, 0, 0, 0, 0, 0, 4'h0));
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    bus.start_i    = 1'b0;
    bus.clear_i    = 1'b0;
    bus.mode_i     = 1'b0;
    bus.chan_en_i  = '0;
    bus.timeout_i  = '0;
    bus.wr_valid_i = '0;
    bus.wr_data_i  = '0;
    $display("[TB] starting eoc_monitor scenarios");
    test_reset();
    test_all_pass();
    test_all_fail();
    test_any_enable();
    test_empty_mask();
    test_timeout();
    test_expiry_race();
    test_first_eoc();
    test_back_to_back();
    test_mid_reset();
    test_clear_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eoc_monitor.md
# eoc_monitor

Multi-channel end-of-computation monitor for the SoC simulation and bring-up flow. It watches one scratch-register write stream per hart or agent and latches each channel's exit code when that channel reports end-of-computation. It then reports a single aggregated completion, pass/fail and exit code, with a programmable cycle timeout. It is the hardware successor to the single-hart JTAG/serial-link/UART exit-code polling loop, and sits beside the SoC register file so that testbenches and on-chip controllers read one status instead of polling.

## Interface
- NumChan, default 4: number of monitored channels (1..32).
- CodeWidth, default 32: scratch write width. Bit 0 is the EOC flag; bits [CodeWidth-1:1] are the exit code.
- TimeoutWidth, default 32: timeout counter width.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  arms the monitor from IDLE, DONE or TIMEOUT.
- clear_i  in  1  returns to IDLE and clears all latched state.
- mode_i  in  1  0 = ALL enabled channels must finish; 1 = ANY enabled channel finishing completes.
- chan_en_i  in  NumChan  channel enable mask, sampled on start_i.
- timeout_i  in  TimeoutWidth  timeout in cycles, sampled on start_i; 0 disables timeout.
- wr_valid_i  in  NumChan  per-channel scratch write strobe.
- wr_data_i  in  NumChan x CodeWidth  per-channel scratch write data.
- busy_o  out  1  high in ARMED.
- done_o  out  1  high in DONE.
- timeout_o  out  1  high in TIMEOUT.
- pass_o  out  1  valid in DONE; high iff every latched code is 0.
- exit_code_o  out  CodeWidth-1  code of the lowest-index done channel with a nonzero code, else 0.
- fail_idx_o  out  $clog2(NumChan) (min 1)  index of that channel, 0 if none.
- chan_done_o  out  NumChan  per-channel EOC-seen flags.

## Operation
- States: IDLE, ARMED, DONE, TIMEOUT.
- Transitions:
  - IDLE/DONE/TIMEOUT to ARMED on start_i.
  - Any state to IDLE on clear_i. clear_i beats start_i when both are asserted.
  - ARMED to DONE on completion.
  - ARMED to TIMEOUT on expiry.
  - start_i while in ARMED is ignored.
- On arm: clear chan_done, all latched codes and the counter; capture chan_en_i and timeout_i.
- Capture: in ARMED, a channel that is enabled, not yet done, and has wr_valid_i high with wr_data_i[0]=1 latches wr_data_i[CodeWidth-1:1] and sets its chan_done bit.
- Ignored writes:
  - writes with bit 0 = 0;
  - writes to disabled channels;
  - writes to channels already done (first EOC wins);
  - all writes outside ARMED.
- Several channels may capture in the same cycle; all are latched.
- Completion is evaluated on the next chan_done vector, including captures in the current cycle.
  - ALL: (next_done & en) == en.
  - ANY: |(next_done & en).
  - en == 0 counts as complete in both modes; DONE follows the first ARMED cycle with pass_o=1.
- Timeout: the counter increments every ARMED cycle. Expiry is when timeout != 0 and counter == timeout-1 with no completion. Completion in the expiry cycle wins (DONE).
- In TIMEOUT, chan_done_o and the latched codes stay frozen so partial results remain readable. pass_o=0.
- Aggregation: pass_o, exit_code_o and fail_idx_o are computed combinationally from the latched codes over done channels.
- Counter width is TimeoutWidth; it cannot wrap, because expiry happens first or timeout is 0 (no-timeout mode saturates at all-ones).

## Timing
- Reset values:
  - state IDLE;
  - busy_o, done_o, timeout_o, pass_o = 0;
  - exit_code_o, fail_idx_o, chan_done_o = 0;
  - counter and latched codes = 0.
- start_i at cycle t: busy_o=1 at t+1.
- A write captured at cycle t: chan_done_o bit set at t+1. If it completes the run, done_o=1 and busy_o=0 at t+1.
- With timeout T armed at cycle t: ARMED spans cycles t+1..t+T; timeout_o=1 at t+T+1.
- rst_i mid-run: next cycle equals the reset state, regardless of other inputs.
- All outputs are registered or derived from registered state only; no input-to-output combinational path.

## Test plan
- NumChan=4, ALL, en=4'hF, T=0. Channels write 0x1 at staggered cycles 5, 9, 9, 20 after arm. Required: done_o exactly one cycle after the cycle-20 write, pass_o=1, exit_code_o=0.
- ALL, en=4'hF. Ch2 writes 0x0000_0007 (code 3), ch1 writes 0x0000_000B (code 5), others write 0x1. Required: pass_o=0, exit_code_o=5, fail_idx_o=1.
- ANY, en=4'b0100. Ch0 writes 0x1 (ignored, disabled), then ch2 writes 0x1. Required: DONE the cycle after the ch2 write, chan_done_o=4'b0100.
- T=100, ALL, only ch0 writes 0x1. Required: timeout_o=1 exactly 101 cycles after start_i, chan_done_o=4'b0001. Rerun with the final channel's EOC in the expiry cycle: required done_o, not timeout_o.
- Ch3 writes 0x2, then 0x5, then 0x3. Required: latched code 2 (0x2 ignored, first EOC 0x5 wins). Also assert rst_i mid-run and, separately, clear_i together with start_i: required IDLE, all outputs zero next cycle.
